// File: rtl/sysid_info_regs.sv
// System-ID info block: build ID/timestamp/user constants, scratch register and a
// prescaled 64-bit uptime counter with coherent hi/lo snapshot, on an Avalon-MM slave.
module sysid_info_regs #(
  parameter logic [31:0]            ID_VALUE   = 32'h0000_0000,
  parameter logic [31:0]            TIMESTAMP  = 32'd1647964715,
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            NUM_USER   = 2,
  parameter logic [32*NUM_USER-1:0] USER_WORDS = '0,
  parameter int unsigned            PRESCALE   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] A_ID      = 32'd0;
  localparam logic [31:0] A_TS      = 32'd1;
  localparam logic [31:0] A_UP_LO   = 32'd2;
  localparam logic [31:0] A_UP_HI   = 32'd3;
  localparam logic [31:0] A_SCRATCH = 32'd4;
  localparam logic [31:0] A_CTRL    = 32'd5;
  localparam logic [31:0] A_USER0   = 32'd6;

  logic [31:0]   word;
  logic [31:0]   rd_mux;
  logic [31:0]   scratch;
  logic [63:0]   uptime;
  logic [31:0]   snap_hi;
  logic [PW-1:0] pre_cnt;
  logic          en;
  logic          ovf;

  logic wr_en;
  logic ctrl_wr;
  logic clr;
  logic ovf_w1c;
  logic wrap_pre;
  logic tick;
  logic wrap;
  logic rd_lo;

  assign word     = 32'(address);
  // A simultaneous read wins over the write.
  assign wr_en    = write & ~read;
  assign ctrl_wr  = wr_en & (word == A_CTRL);
  assign clr      = ctrl_wr & byteenable[0] & writedata[1];
  assign ovf_w1c  = ctrl_wr & byteenable[1] & writedata[8];
  assign wrap_pre = (pre_cnt == PW'(PRESCALE - 1));
  assign tick     = en & wrap_pre;
  assign wrap     = tick & (&uptime);
  assign rd_lo    = read & (word == A_UP_LO);

  // Read data selection
  always_comb begin
    rd_mux = 32'h0;
    case (word)
      A_ID:      rd_mux = ID_VALUE;
      A_TS:      rd_mux = TIMESTAMP;
      A_UP_LO:   rd_mux = uptime[31:0];
      A_UP_HI:   rd_mux = snap_hi;
      A_SCRATCH: rd_mux = scratch;
      A_CTRL:    rd_mux = {23'h0, ovf, 7'h0, en};
      default: begin
        for (int k = 0; k < int'(NUM_USER); k++) begin
          if (word == 32'(k) + A_USER0) rd_mux = USER_WORDS[k*32 +: 32];
        end
      end
    endcase
  end

  // Bus response: fixed one-cycle read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

  // Scratch register with byte-lane writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= 32'h0;
    end else if (wr_en && (word == A_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Control: EN and sticky OVF (a wrap in the clear cycle keeps OVF set)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr && byteenable[0]) en <= writedata[0];
      if (wrap && !clr)  ovf <= 1'b1;
      else if (ovf_w1c) ovf <= 1'b0;
    end
  end

  // Prescaler, uptime counter and hi snapshot; CLR overrides a same-cycle tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      uptime  <= 64'h0;
      snap_hi <= 32'h0;
    end else if (clr) begin
      pre_cnt <= '0;
      uptime  <= 64'h0;
      snap_hi <= 32'h0;
    end else begin
      if (en) pre_cnt <= wrap_pre ? '0 : pre_cnt + PW'(1);
      if (tick) uptime <= uptime + 64'd1;
      if (rd_lo) snap_hi <= uptime[63:32];
    end
  end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Scoreboard bench for sysid_info_regs: reads push expected data, a negedge monitor
// pops and checks data and one-cycle latency whenever readdatavalid is seen.
module tb_sysid_info_regs;

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] mon_e;
  int          mon_c;

  sysid_info_regs #(
    .ID_VALUE  (32'hCAFE_0001),
    .TIMESTAMP (32'd1647964715),
    .ADDR_WIDTH(4),
    .NUM_USER  (2),
    .USER_WORDS(64'h9ABC_DEF0_1234_5678),
    .PRESCALE  (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every valid response must match the oldest outstanding read
  always @(negedge clock) begin
    if (readdatavalid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stray_rdv: readdatavalid=1 with no read outstanding, readdata=%h", readdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        if (readdata !== mon_e) begin
          miscompares++;
          $display("FAIL rdata: got %h expected %h (cycle %0d)", readdata, mon_e, cyc);
        end
        vectors++;
        if (cyc != mon_c) begin
          miscompares++;
          $display("FAIL latency: response at cycle %0d expected cycle %0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Deposit counter state so the next edge sees it (e.g. one clock before a tick)
  task automatic preload(input logic [63:0] u, input logic [1:0] p);
    dut.uptime  <= u;
    dut.pre_cnt <= p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 4'h0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    byteenable = 4'h0;
    @(negedge clock);

    // Uptime with PRESCALE=4: 40 clocks -> 10, then EN=0 freezes it
    do_reset();
    repeat (40) @(negedge clock);
    rd(4'd2, 32'd10);
    wr(4'd5, 32'h0, 4'hF);
    repeat (20) @(negedge clock);
    rd(4'd2, 32'd10);
    rd(4'd2, 32'd10);
    rd(4'd3, 32'd0);
    rd(4'd5, 32'h0);

    // Constants, unmapped words, RO write, scratch lanes, read-wins collision
    do_reset();
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd1, 32'd1647964715);
    rd(4'd6, 32'h1234_5678);
    rd(4'd7, 32'h9ABC_DEF0);
    rd(4'd8, 32'h0);
    rd(4'd15, 32'h0);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd4, 32'h0);
    wr(4'd4, 32'hFFFF_FFFF, 4'hF);
    wr(4'd4, 32'h0, 4'b0101);
    rd(4'd4, 32'hFF00_FF00);
    address    = 4'd4;
    writedata  = 32'h0;
    byteenable = 4'hF;
    read       = 1'b1;
    write      = 1'b1;
    exp_q.push_back(32'hFF00_FF00);
    cyc_q.push_back(cyc + 1);
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    rd(4'd4, 32'hFF00_FF00);
    rd(4'd5, 32'h1);

    // LO read in a tick cycle: pre-increment lo and matching hi snapshot
    preload(64'h0000_0001_FFFF_FFFF, 2'd3);
    rd(4'd2, 32'hFFFF_FFFF);
    rd(4'd3, 32'h1);
    rd(4'd2, 32'h0);
    rd(4'd3, 32'h2);

    // Wrap sets OVF; W1C clears it; set beats a same-cycle W1C
    preload(64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    @(negedge clock);
    rd(4'd5, 32'h101);
    rd(4'd2, 32'h0);
    wr(4'd5, 32'h101, 4'b0011);
    rd(4'd5, 32'h1);
    preload(64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    wr(4'd5, 32'h101, 4'b0011);
    rd(4'd5, 32'h101);
    wr(4'd5, 32'h100, 4'b0010);
    rd(4'd5, 32'h1);

    // CLR coinciding with a tick zeroes uptime and snapshot
    preload(64'h0000_0005_0000_0007, 2'd3);
    rd(4'd2, 32'h7);
    rd(4'd3, 32'h5);
    preload(64'h0000_0005_0000_0009, 2'd3);
    wr(4'd5, 32'h3, 4'b0001);
    rd(4'd3, 32'h0);
    rd(4'd2, 32'h0);
    rd(4'd5, 32'h1);

    // Reset during an outstanding response
    preload(64'h0000_0003_0000_0000, 2'd0);
    rd(4'd2, 32'h0);
    rd(4'd3, 32'h3);
    address = 4'd5;
    read    = 1'b1;
    @(posedge clock);
    #1;
    check("rdv_before_rst", {31'h0, readdatavalid}, 32'h1);
    check("rdata_before_rst", readdata, 32'h1);
    reset_n = 1'b0;
    read    = 1'b0;
    #1;
    check("rdv_in_rst", {31'h0, readdatavalid}, 32'h0);
    check("rdata_in_rst", readdata, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    rd(4'd3, 32'h0);
    rd(4'd4, 32'h0);
    rd(4'd5, 32'h1);
    rd(4'd2, 32'd2);

    repeat (3) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_rdv: %0d reads without response, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
Parametrised successor to the system-ID peripheral. It is an Avalon-MM slave that returns build ID and timestamp constants, plus a configurable bank of user constant words. It also provides a read/write scratch register and a prescaled 64-bit uptime counter with coherent hi/lo snapshot, control and sticky overflow status. It sits on the processor data bus and is used by software to identify the hardware build and to keep coarse time.

Parameters:
ID_VALUE, 32'h0000_0000, system ID constant returned at word 0
TIMESTAMP, 1647964715, build timestamp constant returned at word 1
ADDR_WIDTH, 4, word-address width; legal range 3..8
NUM_USER, 2, number of user constant words; must satisfy 6+NUM_USER <= 2**ADDR_WIDTH
USER_WORDS, {NUM_USER{32'h0}}, packed user constants; word k is at bits [32k+31:32k]
PRESCALE, 1, clocks per uptime tick; must be >= 1

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  word address
read  in  1  read strobe, one cycle per transfer
write  in  1  write strobe, one cycle per transfer
writedata  in  32  write data
byteenable  in  4  write byte lanes
readdata  out  32  read data, registered
readdatavalid  out  1  high for exactly one cycle, one clock after read

Behaviour:
- Reset (async assert, sync release): readdata=0, readdatavalid=0, scratch=0, uptime=0, prescale count=0, hi snapshot=0, EN=1, OVF=0.
- No waitrequest. Fixed read latency of 1: a read sampled at edge N gives readdatavalid=1 and readdata after edge N, held for one cycle. Otherwise readdatavalid=0 and readdata holds its last value.
- If read and write are asserted in the same cycle, the write is ignored and the read is performed.
- Register map (word addresses):
  - 0 ID: read-only (RO), ID_VALUE.
  - 1 TIMESTAMP: RO.
  - 2 UPTIME_LO: RO. Returns uptime[31:0] and copies uptime[63:32] into the hi snapshot in the same cycle.
  - 3 UPTIME_HI: RO. Returns the snapshot, not the live value.
  - 4 SCRATCH: read/write, byte-lane writes per byteenable.
  - 5 CTRL: bit0 EN is read/write (write only if byteenable[0]). Bit1 CLR is write-only, reads 0: writing 1 zeroes uptime, the prescale count and the hi snapshot. Bit8 OVF is sticky and write-1-to-clear via byteenable[1]. Other bits read 0.
  - 6..6+NUM_USER-1: USER[k], RO.
  - All other addresses read 0; writes to them and to RO words have no effect.
- Uptime:
  - When EN=1, the prescale counter runs 0..PRESCALE-1 and uptime increments by 1 on the wrap cycle. With PRESCALE=1, uptime increments every clock.
  - When EN=0, both counters hold.
  - On increment from 2**64-1, uptime wraps to 0 and OVF is set.
- Simultaneous events:
  - CLR and a tick in the same cycle: CLR wins, result is 0.
  - OVF set and W1C in the same cycle: set wins.
  - A read of UPTIME_LO in a tick cycle returns the pre-increment lo and the matching pre-increment hi in the snapshot.
  - A write to CTRL with EN=0 stops counting from the next cycle; the tick in the write cycle still applies.
- Reset asserted mid-transfer: readdatavalid drops immediately; no pending response is issued after release.

Test Plan:
- Reset, then read words 0, 1 and 6 with ID_VALUE=32'hCAFE0001, USER_WORDS[0]=32'h12345678 -> readdata CAFE0001, 1647964715, 12345678, each with readdatavalid exactly one cycle after read. Read of an unmapped address returns 0.
- Write SCRATCH 32'hFFFFFFFF with byteenable 4'b1111, then 32'h00000000 with byteenable 4'b0101, read -> FF00FF00.
- PRESCALE=4, wait 40 clocks after reset, read LO -> 10. Write CTRL=0, wait 20 clocks, read LO -> 10 or 11 depending on alignment, constant on reread.
- Force uptime to 64'h0000_0001_FFFF_FFFF (via bench preload or long run at PRESCALE=1); read LO in the tick cycle -> LO=FFFFFFFF and HI=1, with a later live value of 0x2_00000000 not reflected until the next LO read.
- Count to wrap at 2**64-1 -> CTRL bit8=1. Write CTRL 32'h00000101 -> bit8 clears, EN stays 1. Write CTRL bit1 -> uptime reads 0.
- Assert reset_n low while read is pending -> readdatavalid=0 immediately. After release, all registers are at reset values and no stray readdatavalid occurs.
